// File: rtl/basic_control_unit.sv
// Timing and control unit for the 16-bit basic computer.
// Sequence counter T0..T6, IR decode, per-cycle datapath strobes.
module basic_control_unit #(
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir_outdata,
  input  logic [15:0] ac_outdata,
  input  logic [15:0] dr_outdata,
  input  logic        e_outdata,
  input  logic        fgi,
  input  logic        fgo,
  output logic [3:0]  alu_code,
  output logic [2:0]  bus_sel,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ac_inc,
  output logic        ac_clr,
  output logic        ir_ld,
  output logic        e_ld,
  output logic        e_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        outr_ld,
  output logic        fgi_clr,
  output logic        fgo_clr,
  output logic [2:0]  sc_outdata,
  output logic        halted
);

  logic [2:0] sc;
  logic       i_bit;
  logic       halted_q;
  logic       sc_clr;
  logic       hlt;
  logic [2:0] d;

  assign d          = ir_outdata[14:12];
  assign sc_outdata = sc;
  assign halted     = halted_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc       <= 3'd0;
      i_bit    <= 1'b0;
      halted_q <= HALT_ON_RESET;
    end else if (halted_q) begin
      sc <= 3'd0;
      if (start) halted_q <= 1'b0;
    end else begin
      sc <= sc_clr ? 3'd0 : sc + 3'd1;
      if (sc == 3'd2) i_bit <= ir_outdata[15];
      if (hlt) halted_q <= 1'b1;
    end
  end

  // Outputs are gated by rst_n so a reset cycle never strobes memory.
  always_comb begin
    alu_code = 4'b0000;
    bus_sel  = 3'd0;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_inc   = 1'b0;
    ac_clr   = 1'b0;
    ir_ld    = 1'b0;
    e_ld     = 1'b0;
    e_clr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    outr_ld  = 1'b0;
    fgi_clr  = 1'b0;
    fgo_clr  = 1'b0;
    sc_clr   = 1'b0;
    hlt      = 1'b0;
    if (rst_n && !halted_q) begin
      case (sc)
        3'd0: begin
          bus_sel = 3'd2;
          ar_ld   = 1'b1;
        end
        3'd1: begin
          bus_sel = 3'd7;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          bus_sel = 3'd5;
          ar_ld   = 1'b1;
        end
        3'd3: begin
          if (d == 3'd7) begin
            sc_clr = 1'b1;
            if (!i_bit) begin
              priority case (1'b1)
                ir_outdata[11]: ac_clr = 1'b1;
                ir_outdata[10]: e_clr = 1'b1;
                ir_outdata[9]: begin
                  alu_code = 4'b1001;
                  ac_ld    = 1'b1;
                end
                ir_outdata[8]: begin
                  alu_code = 4'b1010;
                  e_ld     = 1'b1;
                end
                ir_outdata[7]: begin
                  alu_code = 4'b1011;
                  ac_ld    = 1'b1;
                  e_ld     = 1'b1;
                end
                ir_outdata[6]: begin
                  alu_code = 4'b1100;
                  ac_ld    = 1'b1;
                  e_ld     = 1'b1;
                end
                ir_outdata[5]: ac_inc = 1'b1;
                ir_outdata[4]: pc_inc = !ac_outdata[15];
                ir_outdata[3]: pc_inc = ac_outdata[15];
                ir_outdata[2]: pc_inc = (ac_outdata == 16'h0000);
                ir_outdata[1]: pc_inc = !e_outdata;
                ir_outdata[0]: hlt = 1'b1;
                default: ;
              endcase
            end else begin
              priority case (1'b1)
                ir_outdata[11]: begin
                  alu_code = 4'b1101;
                  ac_ld    = 1'b1;
                  fgi_clr  = 1'b1;
                end
                ir_outdata[10]: begin
                  bus_sel = 3'd4;
                  outr_ld = 1'b1;
                  fgo_clr = 1'b1;
                end
                ir_outdata[9]: pc_inc = fgi;
                ir_outdata[8]: pc_inc = fgo;
                default: ;
              endcase
            end
          end else if (i_bit) begin
            bus_sel = 3'd7;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        3'd4: begin
          case (d)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus_sel = 3'd7;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
            end
            3'd3: begin
              bus_sel = 3'd4;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            3'd4: begin
              bus_sel = 3'd1;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            3'd5: begin
              bus_sel = 3'd2;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        3'd5: begin
          sc_clr = 1'b1;
          case (d)
            3'd0: begin
              alu_code = 4'b0001;
              ac_ld    = 1'b1;
            end
            3'd1: begin
              alu_code = 4'b0010;
              ac_ld    = 1'b1;
              e_ld     = 1'b1;
            end
            3'd2: begin
              alu_code = 4'b0011;
              ac_ld    = 1'b1;
            end
            3'd5: begin
              bus_sel = 3'd1;
              pc_ld   = 1'b1;
            end
            3'd6: begin
              dr_inc = 1'b1;
              sc_clr = 1'b0;
            end
            default: ;
          endcase
        end
        3'd6: begin
          sc_clr = 1'b1;
          if (d == 3'd6) begin
            bus_sel = 3'd3;
            mem_wr  = 1'b1;
            pc_inc  = (dr_outdata == 16'h0000);
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_control_unit.sv
// Directed table-driven bench for basic_control_unit.
// Cycle-by-cycle expected decodes plus halt/reset sequences.
module tb_basic_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] ir_outdata, ac_outdata, dr_outdata;
  logic        e_outdata, fgi, fgo;
  logic [3:0]  alu_code;
  logic [2:0]  bus_sel, sc_outdata;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc;
  logic        ac_ld, ac_inc, ac_clr, ir_ld, e_ld, e_clr;
  logic        mem_rd, mem_wr, outr_ld, fgi_clr, fgo_clr, halted;

  always #5 clk = ~clk;

  basic_control_unit #(.HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ir_outdata(ir_outdata), .ac_outdata(ac_outdata),
    .dr_outdata(dr_outdata), .e_outdata(e_outdata),
    .fgi(fgi), .fgo(fgo), .alu_code(alu_code), .bus_sel(bus_sel),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .ac_inc(ac_inc),
    .ac_clr(ac_clr), .ir_ld(ir_ld), .e_ld(e_ld), .e_clr(e_clr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .outr_ld(outr_ld),
    .fgi_clr(fgi_clr), .fgo_clr(fgo_clr),
    .sc_outdata(sc_outdata), .halted(halted)
  );

  localparam logic [16:0] AR_LD   = 17'h10000;
  localparam logic [16:0] AR_INC  = 17'h08000;
  localparam logic [16:0] PC_LD   = 17'h04000;
  localparam logic [16:0] PC_INC  = 17'h02000;
  localparam logic [16:0] DR_LD   = 17'h01000;
  localparam logic [16:0] DR_INC  = 17'h00800;
  localparam logic [16:0] AC_LD   = 17'h00400;
  localparam logic [16:0] AC_INC  = 17'h00200;
  localparam logic [16:0] AC_CLR  = 17'h00100;
  localparam logic [16:0] IR_LD   = 17'h00080;
  localparam logic [16:0] E_LD    = 17'h00040;
  localparam logic [16:0] E_CLR   = 17'h00020;
  localparam logic [16:0] MR      = 17'h00010;
  localparam logic [16:0] MW      = 17'h00008;
  localparam logic [16:0] OUTR_LD = 17'h00004;
  localparam logic [16:0] FGI_CLR = 17'h00002;
  localparam logic [16:0] FGO_CLR = 17'h00001;

  logic [16:0] ctl;
  assign ctl = {ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld,
                ac_inc, ac_clr, ir_ld, e_ld, e_clr, mem_rd, mem_wr,
                outr_ld, fgi_clr, fgo_clr};

  typedef struct {
    logic [15:0] ir;
    logic [15:0] ac;
    logic [15:0] dr;
    logic [2:0]  efg;
    logic [2:0]  sc;
    logic [2:0]  bus;
    logic [3:0]  alu;
    logic [16:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [15:0] ir, input logic [15:0] ac,
                     input logic [15:0] dr, input logic [2:0] efg,
                     input logic [2:0] sc, input logic [2:0] bus,
                     input logic [3:0] alu, input logic [16:0] c);
    vec_t v;
    v.ir = ir; v.ac = ac; v.dr = dr; v.efg = efg;
    v.sc = sc; v.bus = bus; v.alu = alu; v.ctl = c;
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [15:0] ir);
    add(ir, 0, 0, 0, 3'd0, 3'd2, 4'h0, AR_LD);
    add(ir, 0, 0, 0, 3'd1, 3'd7, 4'h0, MR | IR_LD | PC_INC);
    add(ir, 0, 0, 0, 3'd2, 3'd5, 4'h0, AR_LD);
  endtask

  task automatic chk(input string nm, input logic [2:0] sc,
                     input logic [2:0] bus, input logic [3:0] alu,
                     input logic [16:0] c, input logic h);
    checks++;
    if (sc_outdata !== sc || bus_sel !== bus || alu_code !== alu ||
        ctl !== c || halted !== h) begin
      errors++;
      $display("FAIL %s: got sc=%0d bus=%0d alu=%h ctl=%h halted=%b want sc=%0d bus=%0d alu=%h ctl=%h halted=%b",
               nm, sc_outdata, bus_sel, alu_code, ctl, halted,
               sc, bus, alu, c, h);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    ir_outdata = '0; ac_outdata = '0; dr_outdata = '0;
    e_outdata = 1'b0; fgi = 1'b0; fgo = 1'b0;

    // ADD direct
    fetch(16'h1005);
    add(16'h1005, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h1005, 0, 0, 0, 3'd4, 3'd7, 4'h0, MR | DR_LD);
    add(16'h1005, 0, 0, 0, 3'd5, 3'd0, 4'h2, AC_LD | E_LD);
    // AND indirect
    fetch(16'h8005);
    add(16'h8005, 0, 0, 0, 3'd3, 3'd7, 4'h0, MR | AR_LD);
    add(16'h8005, 0, 0, 0, 3'd4, 3'd7, 4'h0, MR | DR_LD);
    add(16'h8005, 0, 0, 0, 3'd5, 3'd0, 4'h1, AC_LD);
    // ISZ, DR reaches zero then not
    fetch(16'h6010);
    add(16'h6010, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h6010, 0, 0, 0, 3'd4, 3'd7, 4'h0, MR | DR_LD);
    add(16'h6010, 0, 0, 0, 3'd5, 3'd0, 4'h0, DR_INC);
    add(16'h6010, 0, 16'h0000, 0, 3'd6, 3'd3, 4'h0, MW | PC_INC);
    fetch(16'h6010);
    add(16'h6010, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h6010, 0, 0, 0, 3'd4, 3'd7, 4'h0, MR | DR_LD);
    add(16'h6010, 0, 0, 0, 3'd5, 3'd0, 4'h0, DR_INC);
    add(16'h6010, 0, 16'h0005, 0, 3'd6, 3'd3, 4'h0, MW);
    // CIR twice, CLA+CLE, skips, CMA+INC
    fetch(16'h7080);
    add(16'h7080, 0, 0, 0, 3'd3, 3'd0, 4'hB, AC_LD | E_LD);
    fetch(16'h7080);
    add(16'h7080, 0, 0, 0, 3'd3, 3'd0, 4'hB, AC_LD | E_LD);
    fetch(16'h7C00);
    add(16'h7C00, 0, 0, 0, 3'd3, 3'd0, 4'h0, AC_CLR);
    fetch(16'h7008);
    add(16'h7008, 16'h8000, 0, 0, 3'd3, 3'd0, 4'h0, PC_INC);
    fetch(16'h7010);
    add(16'h7010, 16'h8000, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    fetch(16'h7004);
    add(16'h7004, 16'h0000, 0, 0, 3'd3, 3'd0, 4'h0, PC_INC);
    fetch(16'h7002);
    add(16'h7002, 0, 0, 3'b100, 3'd3, 3'd0, 4'h0, '0);
    fetch(16'h7220);
    add(16'h7220, 0, 0, 0, 3'd3, 3'd0, 4'h9, AC_LD);
    // I/O
    fetch(16'hF800);
    add(16'hF800, 0, 0, 3'b010, 3'd3, 3'd0, 4'hD, AC_LD | FGI_CLR);
    fetch(16'hF400);
    add(16'hF400, 0, 0, 0, 3'd3, 3'd4, 4'h0, OUTR_LD | FGO_CLR);
    fetch(16'hF100);
    add(16'hF100, 0, 0, 3'b000, 3'd3, 3'd0, 4'h0, '0);
    fetch(16'hF200);
    add(16'hF200, 0, 0, 3'b010, 3'd3, 3'd0, 4'h0, PC_INC);
    // STA, BUN, BSA
    fetch(16'h3005);
    add(16'h3005, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h3005, 0, 0, 0, 3'd4, 3'd4, 4'h0, MW);
    fetch(16'h4005);
    add(16'h4005, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h4005, 0, 0, 0, 3'd4, 3'd1, 4'h0, PC_LD);
    fetch(16'h5005);
    add(16'h5005, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);
    add(16'h5005, 0, 0, 0, 3'd4, 3'd2, 4'h0, MW | AR_INC);
    add(16'h5005, 0, 0, 0, 3'd5, 3'd1, 4'h0, PC_LD);
    // HLT
    fetch(16'h7001);
    add(16'h7001, 0, 0, 0, 3'd3, 3'd0, 4'h0, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 3'd0, 3'd0, 4'h0, '0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      ir_outdata = tbl[i].ir;
      ac_outdata = tbl[i].ac;
      dr_outdata = tbl[i].dr;
      {e_outdata, fgi, fgo} = tbl[i].efg;
      #1;
      chk($sformatf("row%0d_ir%h", i, tbl[i].ir), tbl[i].sc,
          tbl[i].bus, tbl[i].alu, tbl[i].ctl, 1'b0);
      tick();
    end

    ac_outdata = '0; dr_outdata = '0;
    {e_outdata, fgi, fgo} = 3'b000;
    ir_outdata = 16'h3005;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("halt_hold%0d", i), 3'd0, 3'd0, 4'h0, '0, 1'b1);
      tick();
    end
    start = 1'b1;
    #1;
    chk("start_cycle", 3'd0, 3'd0, 4'h0, '0, 1'b1);
    tick();
    start = 1'b0;
    #1;
    chk("start_t0", 3'd0, 3'd2, 4'h0, AR_LD, 1'b0);
    tick();
    start = 1'b1;
    #1;
    chk("run_t1", 3'd1, 3'd7, 4'h0, MR | IR_LD | PC_INC, 1'b0);
    tick();
    start = 1'b0;
    #1;
    chk("start_running", 3'd2, 3'd5, 4'h0, AR_LD, 1'b0);
    tick();
    #1;
    chk("sta_t3", 3'd3, 3'd0, 4'h0, '0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_at_t4", 3'd4, 3'd0, 4'h0, '0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("after_rst", 3'd0, 3'd2, 4'h0, AR_LD, 1'b0);

    ir_outdata = 16'h7001;
    tick();
    tick();
    tick();
    start = 1'b1;
    #1;
    chk("hlt_t3", 3'd3, 3'd0, 4'h0, '0, 1'b0);
    tick();
    start = 1'b0;
    #1;
    chk("hlt_wins", 3'd0, 3'd0, 4'h0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
